// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter_pkg
//  Purpose : Shared definitions for the two-port memory arbiter: FSM state
//            encoding and the transfer-length code for a single word.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_HOLD = 2'b11
    } arb_state_e;

    // Transfer length code for one full word.
    localparam logic [1:0] LEN_WORD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arb2
//  Purpose : Two-way round-robin picker. The search starts at ptr_i; the
//            first requesting port found gets a one-hot grant.
//  Ports   : req_i [1:0]  request per port
//            ptr_i        port with priority this round
//            gnt_o [1:0]  one-hot grant (all zero when nothing requested)
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (ptr_i == 1'b0) begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
        end else begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter
//  Purpose : Shares one memory port between the I-cache (port 0) and the
//            D-cache (port 1). One transaction at a time, round-robin between
//            ports, write before read within a port, watchdog abort with a
//            sticky error flag.
//  Ports   : clk, rst (async, active-high)
//            p_re/p_we/p_raddr/p_waddr/p_rlen/p_wlen/p_wdata : cache requests
//            p_rdata/p_rack/p_wack                            : cache responses
//            m_re/m_we/m_raddr/m_waddr/m_rlen/m_wlen/m_wdata  : memory request
//            m_rdata/m_rack/m_wack                            : memory response
//            err                                              : sticky timeout
//  Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          p_re,
    input  logic [1:0]          p_we,
    input  logic [2*ADDR_W-1:0] p_raddr,
    input  logic [2*ADDR_W-1:0] p_waddr,
    input  logic [2*LEN_W-1:0]  p_rlen,
    input  logic [2*LEN_W-1:0]  p_wlen,
    input  logic [2*DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0]   p_rdata,
    output logic [1:0]          p_rack,
    output logic [1:0]          p_wack,
    output logic                m_re,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_raddr,
    output logic [ADDR_W-1:0]   m_waddr,
    output logic [LEN_W-1:0]    m_rlen,
    output logic [LEN_W-1:0]    m_wlen,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rack,
    input  logic                m_wack,
    output logic                err
);

    // Watchdog counts 0 .. TIMEOUT-1; the abort fires on the last count so the
    // memory enable stays high for exactly TIMEOUT cycles.
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e        state_q;
    logic              rr_ptr_q;
    logic              gnt_q;
    logic [WDOG_W-1:0] wdog_q;

    logic [1:0]        req_any;
    logic [1:0]        gnt_oh;
    logic              gnt_id;
    logic              wdog_expire;
    logic [ADDR_W-1:0] sel_raddr;
    logic [ADDR_W-1:0] sel_waddr;
    logic [LEN_W-1:0]  sel_rlen;
    logic [LEN_W-1:0]  sel_wlen;
    logic [DATA_W-1:0] sel_wdata;

    assign req_any = p_re | p_we;

    rr_arb2 u_rr_arb2 (
        .req_i (req_any),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_oh)
    );

    assign gnt_id    = gnt_oh[1];
    assign sel_raddr = gnt_id ? p_raddr[2*ADDR_W-1:ADDR_W] : p_raddr[ADDR_W-1:0];
    assign sel_waddr = gnt_id ? p_waddr[2*ADDR_W-1:ADDR_W] : p_waddr[ADDR_W-1:0];
    assign sel_rlen  = gnt_id ? p_rlen[2*LEN_W-1:LEN_W]    : p_rlen[LEN_W-1:0];
    assign sel_wlen  = gnt_id ? p_wlen[2*LEN_W-1:LEN_W]    : p_wlen[LEN_W-1:0];
    assign sel_wdata = gnt_id ? p_wdata[2*DATA_W-1:DATA_W] : p_wdata[DATA_W-1:0];

    assign wdog_expire = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            gnt_q    <= 1'b0;
            wdog_q   <= '0;
            p_rdata  <= '0;
            p_rack   <= '0;
            p_wack   <= '0;
            m_re     <= 1'b0;
            m_we     <= 1'b0;
            m_raddr  <= '0;
            m_waddr  <= '0;
            m_rlen   <= '0;
            m_wlen   <= '0;
            m_wdata  <= '0;
            err      <= 1'b0;
        end else begin
            // Ack outputs are single-cycle pulses.
            p_rack <= '0;
            p_wack <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_any) begin
                        gnt_q  <= gnt_id;
                        wdog_q <= '0;
                        // Write first so write-through data lands before a refetch.
                        if (p_we[gnt_id]) begin
                            m_we    <= 1'b1;
                            m_waddr <= sel_waddr;
                            m_wlen  <= sel_wlen;
                            m_wdata <= sel_wdata;
                            state_q <= ST_WR;
                        end else begin
                            m_re    <= 1'b1;
                            m_raddr <= sel_raddr;
                            m_rlen  <= sel_rlen;
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (m_rack) begin
                        m_re          <= 1'b0;
                        p_rdata       <= m_rdata;
                        p_rack[gnt_q] <= 1'b1;
                        state_q       <= ST_HOLD;
                    end else if (wdog_expire) begin
                        m_re    <= 1'b0;
                        err     <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_WR: begin
                    if (m_wack) begin
                        m_we          <= 1'b0;
                        p_wack[gnt_q] <= 1'b1;
                        state_q       <= ST_HOLD;
                    end else if (wdog_expire) begin
                        m_we    <= 1'b0;
                        err     <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Requests are ignored here so the requester can retire its
                    // level request without being granted twice.
                    rr_ptr_q <= ~gnt_q;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_arbiter
//  Purpose : Directed self-checking bench for mem_arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  p_re = '0, p_we = '0;
    logic [63:0] p_raddr = '0, p_waddr = '0, p_wdata = '0;
    logic [3:0]  p_rlen = '0, p_wlen = '0;
    logic [31:0] p_rdata;
    logic [1:0]  p_rack, p_wack;
    logic        m_re, m_we;
    logic [31:0] m_raddr, m_waddr, m_wdata;
    logic [1:0]  m_rlen, m_wlen;
    logic [31:0] m_rdata = '0;
    logic        m_rack = 1'b0, m_wack = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .p_re(p_re), .p_we(p_we), .p_raddr(p_raddr), .p_waddr(p_waddr),
        .p_rlen(p_rlen), .p_wlen(p_wlen), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_rack(p_rack), .p_wack(p_wack),
        .m_re(m_re), .m_we(m_we), .m_raddr(m_raddr), .m_waddr(m_waddr),
        .m_rlen(m_rlen), .m_wlen(m_wlen), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rack(m_rack), .m_wack(m_wack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p_re = '0; p_we = '0; m_rack = 1'b0; m_wack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for the memory request, records its operands, waits
    // lat-1 further cycles and returns a one-cycle ack. Returns at the negedge
    // where the arbiter's response is visible.
    task automatic mem_respond(input logic wr, input int lat, input logic [31:0] rd,
                               output logic seen, output logic [31:0] addr,
                               output logic [31:0] wd);
        int n = 0;
        while (!(wr ? m_we : m_re) && n < 20) begin
            @(negedge clk);
            n++;
        end
        seen = wr ? m_we : m_re;
        addr = wr ? m_waddr : m_raddr;
        wd   = m_wdata;
        repeat (lat - 1) @(negedge clk);
        if (wr) m_wack = 1'b1; else m_rack = 1'b1;
        m_rdata = rd;
        @(negedge clk);
        m_rack = 1'b0;
        m_wack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finished");
        $fatal(1);
    end

    initial begin
        logic        seen;
        logic [31:0] addr, wd;
        logic        bad;
        int          n;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_m_re",   m_re, 0);
        check("rst_m_we",   m_we, 0);
        check("rst_p_rack", p_rack, 0);
        check("rst_err",    err, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- 1: port 0 read, ack after 3 cycles ----------------
        p_raddr[31:0] = 32'h100;
        p_rlen[1:0]   = LEN_WORD;
        p_re          = 2'b01;
        @(negedge clk);
        check("t1_m_re",    m_re, 1);
        check("t1_m_raddr", m_raddr, 32'h100);
        check("t1_m_rlen",  m_rlen, 2'd3);
        // Spurious write ack while reading must be ignored.
        m_wack = 1'b1;
        @(negedge clk);
        m_wack = 1'b0;
        @(negedge clk);
        check("t1_spurious_wack", {m_re, p_wack}, 3'b100);
        m_rack = 1'b1; m_rdata = 32'hDEADBEEF;
        @(negedge clk);
        m_rack = 1'b0;
        check("t1_p_rack",  p_rack, 2'b01);
        check("t1_p_rdata", p_rdata, 32'hDEADBEEF);
        check("t1_m_re_drop", m_re, 0);
        p_re = 2'b00;
        @(negedge clk);
        check("t1_rack_pulse", p_rack, 2'b00);

        // ---------------- 2: both ports read together ----------------
        do_reset();
        p_raddr = {32'h400, 32'h300};
        p_rlen  = {LEN_WORD, LEN_WORD};
        p_re    = 2'b11;
        mem_respond(1'b0, 1, 32'h1111, seen, addr, wd);
        check("t2_first_seen", seen, 1);
        check("t2_first_addr", addr, 32'h300);
        check("t2_first_rack", p_rack, 2'b01);
        p_re = 2'b10;
        mem_respond(1'b0, 2, 32'h2222, seen, addr, wd);
        check("t2_second_addr", addr, 32'h400);
        check("t2_second_rack", p_rack, 2'b10);
        check("t2_second_data", p_rdata, 32'h2222);
        p_re = 2'b00;
        repeat (2) @(negedge clk);
        // Pointer should be back at port 0.
        p_re = 2'b11;
        mem_respond(1'b0, 1, 32'h3333, seen, addr, wd);
        check("t2_ptr_back", addr, 32'h300);
        p_re = 2'b00;

        // ---------------- 3: write before read on port 1 ----------------
        do_reset();
        p_raddr[63:32] = 32'h200;
        p_waddr[63:32] = 32'h204;
        p_wdata[63:32] = 32'h5;
        p_wlen[3:2]    = LEN_WORD;
        p_re = 2'b10; p_we = 2'b10;
        mem_respond(1'b1, 2, 32'h0, seen, addr, wd);
        check("t3_wr_seen",  seen, 1);
        check("t3_wr_addr",  addr, 32'h204);
        check("t3_wr_data",  wd, 32'h5);
        check("t3_p_wack",   {p_wack, p_rack}, 4'b1000);
        check("t3_rdata_kept", p_rdata, 32'h0);
        p_we = 2'b00;
        mem_respond(1'b0, 1, 32'hCAFE, seen, addr, wd);
        check("t3_rd_addr", addr, 32'h200);
        check("t3_p_rack",  {p_wack, p_rack}, 4'b0010);
        p_re = 2'b00;

        // ---------------- 4: watchdog timeout ----------------
        do_reset();
        p_raddr[31:0] = 32'h500;
        p_re = 2'b01;
        n = 0;
        while (!m_re && n < 20) begin @(negedge clk); n++; end
        n = 0; bad = 1'b0;
        while (m_re && n < 30) begin
            if (p_rack != 2'b00) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check("t4_m_re_cycles", n, 8);
        check("t4_err",         err, 1);
        check("t4_no_rack",     {bad, p_rack}, 3'b000);
        p_re = 2'b00;
        repeat (2) @(negedge clk);
        p_raddr[63:32] = 32'h600;
        p_re = 2'b10;
        mem_respond(1'b0, 1, 32'h6666, seen, addr, wd);
        check("t4_next_addr", addr, 32'h600);
        check("t4_next_rack", p_rack, 2'b10);
        check("t4_err_sticky", err, 1);
        p_re = 2'b00;

        // ---------------- 5: reset while in RD ----------------
        do_reset();
        check("t5_err_cleared", err, 0);
        p_raddr[31:0] = 32'h700;
        p_re = 2'b01;
        n = 0;
        while (!m_re && n < 20) begin @(negedge clk); n++; end
        check("t5_in_rd", m_re, 1);
        rst = 1'b1;
        #1;
        check("t5_async_drop", {m_re, m_raddr}, 33'h0);
        p_re = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_rack = 1'b1; m_rdata = 32'hBAD;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m_rack = 1'b0;
            if (p_rack != 2'b00 || m_re) bad = 1'b1;
        end
        check("t5_no_ack_after", bad, 0);

        // ---------------- 6: request held through the ack cycle ----------------
        do_reset();
        p_raddr[31:0] = 32'h800;
        p_re = 2'b01;
        mem_respond(1'b0, 1, 32'h8888, seen, addr, wd);
        check("t6_rack", p_rack, 2'b01);
        @(negedge clk);
        p_re = 2'b00;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m_re) bad = 1'b1;
        end
        check("t6_no_regrant", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
